sn_cmd_decoder_multi: RTL and testbench

- Parametrised successor to the single-chip SN76489 byte decoder.
- Accepts command bytes for NUM_CHIPS independent PSG instances through a ready/valid input FIFO.
- Decodes latch and data bytes per chip, with correct chip semantics:
  - a latch byte writes the low bits immediately;
  - a data byte writes to the register latched for that chip.
- Holds a shadow register file (readable via a combinational port) and emits one load strobe per register update toward the tone/noise/attenuation generators.

---
 rtl/sn_cmd_decoder_multi.sv | 139 +++++++++++++
 tb/tb_sn_cmd_decoder_multi.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/sn_cmd_decoder_multi.sv
// Multi-chip SN76489 command decoder: input FIFO, per-chip latch
// tracking, shadow register file and one load strobe per update.
module sn_cmd_decoder_multi #(
    parameter int NUM_CHIPS  = 2,
    parameter int CHIP_W     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    input  logic [CHIP_W-1:0] in_chip,
    output logic              in_ready,
    output logic              out_load,
    output logic [CHIP_W-1:0] out_chip,
    output logic [2:0]        out_adr,
    output logic [9:0]        out_value,
    output logic              noise_rst,
    input  logic [CHIP_W-1:0] rd_chip,
    input  logic [2:0]        rd_adr,
    output logic [9:0]        rd_value
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [2:0] NOISE_ADR = 3'd6;

    logic [CHIP_W+7:0] mem [FIFO_DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;

    logic [9:0]        shadow [NUM_CHIPS][8];
    logic [2:0]        latched [NUM_CHIPS];

    logic [CHIP_W-1:0] h_chip;
    logic [7:0]        h_data;
    logic              chip_ok;
    logic              do_load;
    logic [2:0]        cur_latch;
    logic [9:0]        cur_reg;
    logic [2:0]        r;
    logic [9:0]        new_val;
    logic              is_noise;
    logic              is_att;
    logic              tone_lo;
    logic              tone_hi;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign in_ready = !full;
    assign push     = in_valid && !full;
    assign pop      = !empty;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {in_chip, in_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    assign {h_chip, h_data} = mem[rd_ptr[AW-1:0]];
    assign chip_ok = ({1'b0, h_chip} < (CHIP_W+1)'(NUM_CHIPS));
    assign do_load = pop && chip_ok;

    always_comb begin
        cur_latch = '0;
        cur_reg   = '0;
        for (int c = 0; c < NUM_CHIPS; c++) begin
            if (h_chip == CHIP_W'(c)) cur_latch = latched[c];
        end
        r = h_data[7] ? h_data[6:4] : cur_latch;
        for (int c = 0; c < NUM_CHIPS; c++) begin
            if (h_chip == CHIP_W'(c)) cur_reg = shadow[c][r];
        end
        is_noise = (r == NOISE_ADR);
        is_att   = r[0];
        tone_lo  = h_data[7] && !is_att && !is_noise;
        tone_hi  = !h_data[7] && !is_att && !is_noise;
        new_val  = cur_reg;
        unique case (1'b1)
            is_noise: new_val = {7'd0, h_data[2:0]};
            is_att:   new_val = {6'd0, h_data[3:0]};
            tone_lo:  new_val = {cur_reg[9:4], h_data[3:0]};
            tone_hi:  new_val = {h_data[5:0], cur_reg[3:0]};
            default:  new_val = cur_reg;
        endcase
    end

    // Register file is written at the pop edge so readback tracks the strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_load  <= 1'b0;
            noise_rst <= 1'b0;
            out_chip  <= '0;
            out_adr   <= '0;
            out_value <= '0;
            for (int c = 0; c < NUM_CHIPS; c++) begin
                latched[c] <= '0;
                for (int a = 0; a < 8; a++) begin
                    shadow[c][a] <= (a % 2 == 1) ? 10'h00F : 10'h000;
                end
            end
        end else begin
            out_load  <= do_load;
            noise_rst <= do_load && is_noise;
            if (do_load) begin
                out_chip  <= h_chip;
                out_adr   <= r;
                out_value <= new_val;
                for (int c = 0; c < NUM_CHIPS; c++) begin
                    if (h_chip == CHIP_W'(c)) begin
                        latched[c]   <= r;
                        shadow[c][r] <= new_val;
                    end
                end
            end
        end
    end

    always_comb begin
        rd_value = '0;
        for (int c = 0; c < NUM_CHIPS; c++) begin
            if (rd_chip == CHIP_W'(c)) rd_value = shadow[c][rd_adr];
        end
    end

endmodule

// File: tb/tb_sn_cmd_decoder_multi.sv
// Scoreboard bench for sn_cmd_decoder_multi: driver queues expected
// strobes, a negedge monitor pops and compares them.
module tb_sn_cmd_decoder_multi;
    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic [1:0] in_chip;
    logic       in_ready;
    logic       out_load;
    logic [1:0] out_chip;
    logic [2:0] out_adr;
    logic [9:0] out_value;
    logic       noise_rst;
    logic [1:0] rd_chip;
    logic [2:0] rd_adr;
    logic [9:0] rd_value;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [1:0] chip;
        logic [2:0] adr;
        logic [9:0] val;
        logic       nr;
    } exp_t;

    exp_t sbq[$];

    sn_cmd_decoder_multi #(
        .NUM_CHIPS(2),
        .CHIP_W(2),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_chip(in_chip),
        .in_ready(in_ready),
        .out_load(out_load),
        .out_chip(out_chip),
        .out_adr(out_adr),
        .out_value(out_value),
        .noise_rst(noise_rst),
        .rd_chip(rd_chip),
        .rd_adr(rd_adr),
        .rd_value(rd_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic rd(input logic [1:0] c, input logic [2:0] a,
                      input logic [9:0] exp);
        rd_chip = c;
        rd_adr  = a;
        #1;
        chk($sformatf("rd(%0d,%0d)", c, a), {22'd0, rd_value}, {22'd0, exp});
    endtask

    task automatic send(input logic [1:0] c, input logic [7:0] d,
                        input bit exp_on, input logic [2:0] a,
                        input logic [9:0] v, input bit nr);
        exp_t e;
        in_valid = 1'b1;
        in_chip  = c;
        in_data  = d;
        chk($sformatf("in_ready byte 0x%0h", d), {31'd0, in_ready}, 32'd1);
        if (exp_on) begin
            e.chip = c;
            e.adr  = a;
            e.val  = v;
            e.nr   = nr;
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n && out_load) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected strobe: chip=%0d adr=%0d val=0x%0h",
                         out_chip, out_adr, out_value);
            end else begin
                exp_t e;
                exp_t g;
                e = sbq.pop_front();
                g = {out_chip, out_adr, out_value, noise_rst};
                checks++;
                if (g !== e) begin
                    errors++;
                    $display("FAIL strobe: got chip=%0d adr=%0d val=0x%0h nr=%0d want chip=%0d adr=%0d val=0x%0h nr=%0d",
                             g.chip, g.adr, g.val, g.nr,
                             e.chip, e.adr, e.val, e.nr);
                end
            end
        end else if (rst_n && noise_rst) begin
            checks++;
            errors++;
            $display("FAIL noise_rst without load: got 1 want 0");
        end
    end

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_chip  = '0;
        rd_chip  = '0;
        rd_adr   = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset out_load", {31'd0, out_load}, 32'd0);
        chk("reset out_value", {22'd0, out_value}, 32'd0);
        chk("reset out_adr", {29'd0, out_adr}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        rd(2'd0, 3'd1, 10'h00F);
        rd(2'd1, 3'd7, 10'h00F);
        rd(2'd0, 3'd0, 10'h000);
        rd(2'd1, 3'd6, 10'h000);

        // Tone latch then data, with latency and back-to-back timing
        send(2'd0, 8'h8E, 1, 3'd0, 10'h00E, 0);
        chk("latency not yet", {31'd0, out_load}, 32'd0);
        send(2'd0, 8'h0F, 1, 3'd0, 10'h0FE, 0);
        chk("latency load1", {31'd0, out_load}, 32'd1);
        chk("latency val1", {22'd0, out_value}, 32'h00E);
        @(posedge clk);
        #1;
        chk("b2b load2", {31'd0, out_load}, 32'd1);
        chk("b2b val2", {22'd0, out_value}, 32'h0FE);
        @(posedge clk);
        #1;
        chk("idle load", {31'd0, out_load}, 32'd0);
        chk("hold value", {22'd0, out_value}, 32'h0FE);
        rd(2'd0, 3'd0, 10'h0FE);

        // Noise register, latch and data both pulse noise_rst
        send(2'd1, 8'hE5, 1, 3'd6, 10'h005, 1);
        send(2'd1, 8'h02, 1, 3'd6, 10'h002, 1);

        // Interleaved chips
        send(2'd0, 8'hA3, 1, 3'd2, 10'h003, 0);
        send(2'd1, 8'hC7, 1, 3'd4, 10'h007, 0);
        send(2'd0, 8'h3F, 1, 3'd2, 10'h3F3, 0);
        send(2'd1, 8'h01, 1, 3'd4, 10'h017, 0);
        repeat (3) @(posedge clk);
        #1;
        rd(2'd0, 3'd2, 10'h3F3);
        rd(2'd1, 3'd4, 10'h017);
        rd(2'd0, 3'd0, 10'h0FE);
        rd(2'd1, 3'd6, 10'h002);

        // Six back-to-back bytes, one to a nonexistent chip
        send(2'd0, 8'h9C, 1, 3'd1, 10'h00C, 0);
        send(2'd1, 8'hF3, 1, 3'd7, 10'h003, 0);
        send(2'd3, 8'h80, 0, 3'd0, 10'h000, 0);
        send(2'd0, 8'h05, 1, 3'd1, 10'h005, 0);
        send(2'd1, 8'h2A, 1, 3'd7, 10'h00A, 0);
        send(2'd0, 8'hD9, 1, 3'd5, 10'h009, 0);
        repeat (3) @(posedge clk);
        #1;
        rd(2'd0, 3'd1, 10'h005);
        rd(2'd1, 3'd7, 10'h00A);
        rd(2'd0, 3'd5, 10'h009);
        rd(2'd0, 3'd0, 10'h0FE);

        // Reset mid-stream: only the first byte's strobe reaches the monitor
        send(2'd0, 8'h9A, 1, 3'd1, 10'h00A, 0);
        send(2'd0, 8'hB5, 0, 3'd0, 10'h000, 0);
        send(2'd0, 8'h84, 0, 3'd0, 10'h000, 0);
        rst_n = 1'b0;
        #1;
        chk("midrst in_ready", {31'd0, in_ready}, 32'd1);
        chk("midrst out_load", {31'd0, out_load}, 32'd0);
        chk("midrst out_value", {22'd0, out_value}, 32'd0);
        rd(2'd0, 3'd1, 10'h00F);
        rd(2'd0, 3'd3, 10'h00F);
        rd(2'd1, 3'd7, 10'h00F);
        rd(2'd0, 3'd2, 10'h000);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("post-rst out_load", {31'd0, out_load}, 32'd0);
        rd(2'd0, 3'd0, 10'h000);
        send(2'd0, 8'h05, 1, 3'd0, 10'h050, 0);
        send(2'd1, 8'h3C, 1, 3'd0, 10'h3C0, 0);
        repeat (4) @(posedge clk);
        #1;
        rd(2'd0, 3'd0, 10'h050);
        rd(2'd1, 3'd0, 10'h3C0);
        chk("scoreboard drained", sbq.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
